bin_to_bcd_seq_disp: RTL and testbench

Parametrised, sequential binary-to-BCD converter with seven-segment decode for the scoreboard and timer displays. A start/busy/done handshake launches a shift-and-add-3 (double-dabble) conversion that retires one input bit per clock. Results for DIGITS decimal digits are held in registers, with overflow saturation and optional leading-zero blanking. It supersedes the fixed 6-bit, 2-digit combinational converter and is the block that wider score and time values pass through before the display mux.

---
 rtl/bin_to_bcd_seq_disp.sv | 147 ++++++++++++++
 tb/tb_bin_to_bcd_seq_disp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_disp.sv
// bin_to_bcd_seq_disp
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock)
// with a registered, saturating result and a seven-segment decode per digit.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     launch a conversion (accepted only while idle)
//   bin_in    IN_W-bit unsigned value, sampled on the accepting edge
//   blank_lz  1 = blank leading-zero digits (digit 0 is always shown)
//   busy      conversion in progress
//   done      one-cycle pulse when a new result is valid
//   overflow  last result exceeded 10^DIGITS-1 (bcd saturated to all nines)
//   bcd       registered result, digit k at [4k+3:4k]
//   seg       active-low {g,f,e,d,c,b,a} pattern, digit k at [7k+6:7k]
//
// state | meaning
// IDLE  | holding last result, waiting for start
// SHIFT | one double-dabble iteration per clock, IN_W iterations total
module bin_to_bcd_seq_disp #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] shift_q;
  logic [BW-1:0]   scratch_q, scratch_adj, scratch_nxt;
  logic            sticky_q, sticky_nxt;
  logic [CW-1:0]   cnt_q;
  logic            last;
  logic [BW-1:0]   bcd_q;
  logic            ovf_q, done_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Add-3 correction per digit, no carry between digits.
  always_comb begin
    scratch_adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5)
        scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
  end

  // A bit falling off the top digit means the value no longer fits.
  assign scratch_nxt = {scratch_adj[BW-2:0], shift_q[IN_W-1]};
  assign sticky_nxt  = sticky_q | scratch_adj[BW-1];
  assign last        = (cnt_q == CW'(IN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
          end
        end
        SHIFT: begin
          shift_q   <= shift_q << 1;
          scratch_q <= scratch_nxt;
          sticky_q  <= sticky_nxt;
          cnt_q     <= cnt_q + 1'b1;
          done_q    <= last;
          if (last) begin
            bcd_q <= sticky_nxt ? {DIGITS{4'h9}} : scratch_nxt;
            ovf_q <= sticky_nxt;
          end
        end
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign busy     = (state == SHIFT);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;

  // Walk from the top digit down; a digit is blank until the first nonzero.
  always_comb begin
    logic seen;
    seg  = '1;
    seen = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (bcd_q[4*k +: 4] != 4'd0) seen = 1'b1;
      if (blank_lz && !seen && (k != 0)) seg[7*k +: 7] = 7'h7F;
      else                               seg[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq_disp.sv
// Self-checking bench for bin_to_bcd_seq_disp: a default instance (14-bit, 4
// digits) and a small instance (6-bit, 2 digits). Expected results are pushed
// to a queue at the accepting edge and popped when done pulses.
module tb_bin_to_bcd_seq_disp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_a = 1'b0, blank_a = 1'b0;
  logic [13:0] bin_a = '0;
  logic        busy_a, done_a, ovf_a;
  logic [15:0] bcd_a;
  logic [27:0] seg_a;

  logic        start_b = 1'b0, blank_b = 1'b0;
  logic [5:0]  bin_b = '0;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [13:0] seg_b;

  bin_to_bcd_seq_disp dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a), .blank_lz(blank_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .bcd(bcd_a), .seg(seg_a)
  );

  bin_to_bcd_seq_disp #(.IN_W(6), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b), .blank_lz(blank_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .bcd(bcd_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {overflow, bcd} for a value shown on 'digits' decimal digits
  function automatic logic [16:0] ref_conv(input int val, input int digits);
    logic [15:0] b;
    int lim, v;
    b = '0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (val >= lim) begin
      for (int i = 0; i < digits; i++) b[4*i +: 4] = 4'h9;
      return {1'b1, b};
    end
    v = val;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {1'b0, b};
  endfunction

  function automatic logic [27:0] ref_seg(input logic [15:0] b, input logic blank, input int digits);
    logic [6:0]  lut [10];
    logic [27:0] s;
    logic        seen;
    lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    s = '0;
    seen = 1'b0;
    for (int i = digits - 1; i >= 0; i--) begin
      if (b[4*i +: 4] != 4'd0) seen = 1'b1;
      if (blank && !seen && i != 0) s[7*i +: 7] = 7'h7F;
      else s[7*i +: 7] = lut[b[4*i +: 4]];
    end
    return s;
  endfunction

  task automatic launch_a(input int val, input logic blank);
    logic [16:0] r;
    logic [15:0] prev;
    @(negedge clk);
    prev = bcd_a;
    bin_a = 14'(val);
    blank_a = blank;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    bin_a = 14'($urandom);
    r = ref_conv(val, 4);
    q_a.push_back('{r[15:0], r[16], cyc});
    check("a_busy_after_accept", 32'(busy_a), 32'd1);
    check("a_bcd_held_at_accept", 32'(bcd_a), 32'(prev));
  endtask

  task automatic wait_a(input logic drop_start);
    logic got;
    exp_t e;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_a) begin
        got = 1'b1;
        break;
      end
    end
    if (drop_start) start_a = 1'b0;
    check("a_done_seen", 32'(got), 32'd1);
    if (got && q_a.size() > 0) begin
      e = q_a.pop_front();
      check("a_bcd", 32'(bcd_a), 32'(e.bcd));
      check("a_overflow", 32'(ovf_a), 32'(e.ovf));
      check("a_latency", 32'(cyc - e.acc), 32'd14);
      check("a_busy_in_done", 32'(busy_a), 32'd0);
      check("a_seg", 32'(seg_a), 32'(ref_seg(e.bcd, blank_a, 4)));
      @(negedge clk);
      check("a_done_single", 32'(done_a), 32'd0);
    end
  endtask

  task automatic launch_b(input int val, input logic blank);
    logic [16:0] r;
    @(negedge clk);
    bin_b = 6'(val);
    blank_b = blank;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    bin_b = 6'($urandom);
    r = ref_conv(val, 2);
    q_b.push_back('{r[15:0], r[16], cyc});
  endtask

  task automatic wait_b();
    logic got;
    exp_t e;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_b) begin
        got = 1'b1;
        break;
      end
    end
    check("b_done_seen", 32'(got), 32'd1);
    if (got && q_b.size() > 0) begin
      e = q_b.pop_front();
      check("b_bcd", 32'(bcd_b), 32'(e.bcd));
      check("b_overflow", 32'(ovf_b), 32'(e.ovf));
      check("b_latency", 32'(cyc - e.acc), 32'd6);
      check("b_seg", 32'(seg_b), 32'(ref_seg(e.bcd, blank_b, 2)));
    end
  endtask

  task automatic count_dones_a(input int cycles, output int n_done);
    n_done = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
  endtask

  initial begin
    int nd;
    int acc0;
    logic [16:0] r;

    // reset state
    #12;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_seg", 32'(seg_a), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    blank_a = 1'b1;
    #1;
    check("rst_seg_blank", 32'(seg_a), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    blank_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // zero
    launch_a(0, 1'b0);
    wait_a(1'b0);
    check("zero_digit0", 32'(seg_a[6:0]), 32'h40);
    blank_a = 1'b1;
    #1;
    check("zero_blank_upper", 32'(seg_a[27:7]), 32'({7'h7F, 7'h7F, 7'h7F}));

    // in-range values
    launch_a(9999, 1'b0);
    wait_a(1'b0);
    launch_a(1234, 1'b1);
    wait_a(1'b0);
    check("1234_no_blank", 32'(seg_a), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
    launch_a(7, 1'b1);
    wait_a(1'b0);
    check("7_digit0", 32'(seg_a[6:0]), 32'h78);
    check("7_blank_upper", 32'(seg_a[27:7]), 32'({7'h7F, 7'h7F, 7'h7F}));

    // overflow saturation, then recovery
    launch_a(10000, 1'b0);
    wait_a(1'b0);
    check("10000_bcd", 32'(bcd_a), 32'h9999);
    launch_a(16383, 1'b0);
    wait_a(1'b0);
    check("16383_ovf", 32'(ovf_a), 32'd1);
    launch_a(5, 1'b0);
    wait_a(1'b0);
    check("5_ovf_cleared", 32'(ovf_a), 32'd0);

    // reset mid-conversion aborts
    launch_a(555, 1'b0);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ovf", 32'(ovf_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    void'(q_a.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_dones_a(25, nd);
    check("abort_no_done", 32'(nd), 32'd0);
    check("abort_idle", 32'(busy_a), 32'd0);
    launch_a(555, 1'b0);
    wait_a(1'b0);
    check("555_after_abort", 32'(bcd_a), 32'h0555);

    // start held high: one result per 15 cycles
    @(negedge clk);
    bin_a = 14'd42;
    blank_a = 1'b0;
    start_a = 1'b1;
    acc0 = cyc + 1;
    r = ref_conv(42, 4);
    for (int k = 0; k < 3; k++) q_a.push_back('{r[15:0], r[16], acc0 + 15 * k});
    wait_a(1'b0);
    wait_a(1'b0);
    wait_a(1'b1);
    count_dones_a(20, nd);
    check("held_stop_no_done", 32'(nd), 32'd0);

    // start during busy is ignored
    launch_a(42, 1'b0);
    repeat (4) @(negedge clk);
    bin_a = 14'd99;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_a(1'b0);
    count_dones_a(20, nd);
    check("ignored_no_done", 32'(nd), 32'd0);
    check("ignored_bcd", 32'(bcd_a), 32'h0042);

    // small instance
    launch_b(63, 1'b0);
    wait_b();
    check("b_63", 32'(bcd_b), 32'h63);
    launch_b(0, 1'b1);
    wait_b();
    check("b_0", 32'(bcd_b), 32'h00);
    for (int v = 0; v < 64; v++) begin
      launch_b(v, 1'(v & 1));
      wait_b();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
